fifo_rd_ctrl: RTL and testbench
===============================

// Module: fifo_rd_ctrl
// PURPOSE
//   Read-domain controller of the asynchronous FIFO in the AHB-Lite/SPI bridge. It is the counterpart of the write side.
//   It synchronizes the Gray write pointer into rd_clk and keeps the binary/Gray read pointer.
//   It generates a registered empty flag and occupancy estimate, and pops words from the shared dual-port RAM into a registered output.
// PARAMETERS
//   DATA_WIDTH   41  width of one FIFO word (matches write side)
//   ADDR_WIDTH   4   RAM address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//   SYNC_STAGES  2   flops in the write-pointer synchronizer (>=2)
// PORTS
//   rd_clk        in   1             read-domain clock
//   rd_rst_n      in   1             synchronous, active-low reset
//   wq_wptr_gray  in   ADDR_WIDTH+1  Gray write pointer from write domain (asynchronous to rd_clk)
//   rd_en         in   1             pop request
//   mem_raddr     out  ADDR_WIDTH    RAM read address = rbin[ADDR_WIDTH-1:0] (combinational from reg)
//   mem_rdata     in   DATA_WIDTH    RAM word at mem_raddr (combinational read)
//   rd_data       out  DATA_WIDTH    popped word, registered
//   rd_valid      out  1             1-cycle pulse: rd_data updated this cycle
//   empty         out  1             registered empty flag
//   rptr_gray     out  ADDR_WIDTH+1  Gray read pointer to write domain, registered
//   rd_level      out  ADDR_WIDTH+1  occupancy seen from read domain, 0..2**ADDR_WIDTH
//   underflow     out  1             1-cycle pulse: rd_en while empty
// BEHAVIOUR
//   Reset (rd_rst_n=0 at posedge rd_clk):
//     - rbin=0, rptr_gray=0, all sync flops=0.
//     - empty=1, rd_valid=0, rd_data=0, rd_level=0, underflow=0.
//     - Reset dominates rd_en. Mid-operation it discards the pointer state next edge.
//     - The write side must be reset in the same window.
//   Synchronizer: wq_wptr_gray passes through SYNC_STAGES flops to give wsync. There is no other logic before the last stage.
//   pop = rd_en & ~empty (empty is the registered flag).
//     - rbin_next = rbin + pop, modulo 2**(ADDR_WIDTH+1). The MSB is the wrap bit.
//     - rgray_next = rbin_next ^ (rbin_next >> 1).
//     - rbin <= rbin_next; rptr_gray <= rgray_next.
//     - empty <= (rgray_next == wsync). This is pessimistic: a write reaches empty=0 SYNC_STAGES+1 edges after wq_wptr_gray changes.
//   Data path: on pop, rd_data <= mem_rdata (address = pre-increment rbin) and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds.
//     - Latency rd_en -> rd_valid is 1 cycle.
//     - Back-to-back pops are allowed every cycle while empty=0.
//   Underflow: rd_en & empty gives underflow <= 1 for one cycle. Pointers, rd_data and rd_valid are unchanged. The pop is dropped, not queued.
//   rd_level <= gray2bin(wsync) - rbin_next, modulo 2**(ADDR_WIDTH+1). It never exceeds 2**ADDR_WIDTH when the write side respects full.
//   Simultaneous pop and wsync change: empty/rd_level use both the new wsync and rbin_next in the same edge.
//   Pointer wrap: rbin 31->0 (ADDR_WIDTH=4) with Gray 10000->00000. mem_raddr wraps 15->0 every 16 pops.
//   No combinational path from rd_en to any output except mem_raddr (none: mem_raddr is from a register).
// TESTING
//   1. Reset: rd_rst_n=0 for 3 cycles, wq_wptr_gray=5'b00011 -> empty=1, rd_valid=0, rptr_gray=0, rd_level=0.
//   2. Single word: wq_wptr_gray 0->5'b00001, mem_rdata=41'h1_2345_6789A.
//      - empty falls on the 3rd edge.
//      - rd_en for 1 cycle -> next cycle rd_valid=1, rd_data=41'h1_2345_6789A, empty=1, rptr_gray=5'b00001.
//   3. Underflow: empty=1, rd_en=1 for 2 cycles -> underflow=1 both cycles, rptr_gray unchanged, rd_valid=0.
//   4. Full depth: wq_wptr_gray=5'b11000 (bin 16), rbin=0 -> rd_level=16, empty=0.
//      - 16 back-to-back pops -> mem_raddr 0..15, empty=1 after the 16th, rptr_gray=5'b11000.
//   5. Wrap: stream 40 words with the write pointer kept ahead -> mem_raddr wraps 15->0 twice, rptr_gray passes 10000->00000.
//      - rd_data order matches the write order.
//   6. Reset mid-op: after 5 pops assert rd_rst_n=0 for 1 cycle with rd_en=1 -> next edge rbin=0, empty=1, rd_valid=0, no pop.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: write-pointer synchronizer, binary/Gray
// read pointer, registered empty/level flags and a registered pop data path.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH  = 41,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [ADDR_WIDTH:0]   wq_wptr_gray,
  input  logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         sync_d [SYNC_STAGES];
  logic [PW-1:0]         wsync;
  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rptr_gray_q, rptr_gray_d;
  logic                  empty_q, empty_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [PW-1:0]         rd_level_q, rd_level_d;
  logic                  underflow_q, underflow_d;
  logic                  pop;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain: nothing may sit between the async input and the last stage.
  always_comb begin
    sync_d[0] = wq_wptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign wsync = sync_q[SYNC_STAGES-1];

  // Empty and level both look at the post-pop pointer so a pop and a new wsync
  // landing on the same edge are resolved together.
  always_comb begin
    pop         = rd_en & ~empty_q;
    rbin_d      = rbin_q + {{(PW-1){1'b0}}, pop};
    rptr_gray_d = rbin_d ^ (rbin_d >> 1);
    empty_d     = (rptr_gray_d == wsync);
    rd_level_d  = gray2bin(wsync) - rbin_d;
    rd_data_d   = pop ? mem_rdata : rd_data_q;
    rd_valid_d  = pop;
    underflow_d = rd_en & empty_q;
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      empty_q     <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_level_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      empty_q     <= empty_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_level_q  <= rd_level_d;
      underflow_q <= underflow_d;
    end
  end

  assign mem_raddr = rbin_q[ADDR_WIDTH-1:0];
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign empty     = empty_q;
  assign rptr_gray = rptr_gray_q;
  assign rd_level  = rd_level_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: the bench plays the write side and keeps a queue-based
// reference model of what the read side must show on every cycle.
module tb_fifo_rd_ctrl;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n;
  logic [4:0]  wq_wptr_gray;
  logic        rd_en;
  logic [3:0]  mem_raddr;
  logic [40:0] mem_rdata;
  logic [40:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic [4:0]  rptr_gray;
  logic [4:0]  rd_level;
  logic        underflow;

  logic [40:0] mem [16];
  assign mem_rdata = mem[mem_raddr];

  fifo_rd_ctrl #(.DATA_WIDTH(41), .ADDR_WIDTH(4), .SYNC_STAGES(2)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .wq_wptr_gray(wq_wptr_gray), .rd_en(rd_en),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .rptr_gray(rptr_gray), .rd_level(rd_level), .underflow(underflow)
  );

  initial forever #5 rd_clk = ~rd_clk;

  int compared = 0;
  int mismatched = 0;

  // Write side state and the ordered list of words the reader still owes us.
  int          wcnt = 0;
  logic [40:0] exp_q [$];

  // Reference model: counts are plain integers, the synchronizer is a two-deep history.
  int          m_rcnt = 0;
  bit          m_empty = 1'b1;
  bit          m_valid = 1'b0;
  logic [40:0] m_data = '0;
  int          m_level = 0;
  bit          m_under = 1'b0;
  int          w_hist0 = 0;
  int          w_hist1 = 0;
  bit          started = 1'b0;

  int          wrap_gray_seen = 0;
  int          raddr_wraps = 0;
  logic [4:0]  prev_gray = '0;
  logic [3:0]  prev_raddr = '0;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic en);
    rd_rst_n = rst_n;
    rd_en    = en;
    @(negedge rd_clk);
  endtask

  task automatic writeWord(input logic [40:0] word);
    mem[wcnt % 16] = word;
    exp_q.push_back(word);
    wcnt++;
    wq_wptr_gray = gray5(wcnt);
  endtask

  task automatic resetWriteSide();
    wcnt = 0;
    exp_q.delete();
    wq_wptr_gray = '0;
  endtask

  function automatic logic [40:0] randWord();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[40:0];
  endfunction

  initial forever begin
    @(posedge rd_clk);
    started = 1'b1;
    if (!rd_rst_n) begin
      m_rcnt = 0; m_empty = 1'b1; m_valid = 1'b0; m_data = '0;
      m_level = 0; m_under = 1'b0; w_hist0 = 0; w_hist1 = 0;
    end else begin
      bit do_pop;
      do_pop  = rd_en && !m_empty;
      m_under = rd_en && m_empty;
      if (do_pop) begin
        m_rcnt++;
        m_data = exp_q.pop_front();
      end
      m_valid = do_pop;
      m_empty = ((m_rcnt % 32) == (w_hist1 % 32));
      m_level = (w_hist1 - m_rcnt) & 31;
      w_hist1 = w_hist0;
      w_hist0 = wcnt;
    end
  end

  initial forever begin
    @(negedge rd_clk);
    if (started) begin
      checkOutput("empty", 64'(empty), 64'(m_empty));
      checkOutput("rd_valid", 64'(rd_valid), 64'(m_valid));
      checkOutput("rd_data", 64'(rd_data), 64'(m_data));
      checkOutput("rptr_gray", 64'(rptr_gray), 64'(gray5(m_rcnt)));
      checkOutput("rd_level", 64'(rd_level), 64'(m_level));
      checkOutput("underflow", 64'(underflow), 64'(m_under));
      checkOutput("mem_raddr", 64'(mem_raddr), 64'(m_rcnt % 16));
      if (prev_gray == 5'b10000 && rptr_gray == 5'b00000) wrap_gray_seen++;
      if (prev_raddr == 4'd15 && mem_raddr == 4'd0) raddr_wraps++;
      prev_gray  = rptr_gray;
      prev_raddr = mem_raddr;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start_pops;
    int cycles;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rd_rst_n = 1'b0;
    rd_en = 1'b0;
    wq_wptr_gray = 5'b00011;
    @(negedge rd_clk);

    $display("[TB] reset with a nonzero write pointer");
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("rst_rptr_gray", 64'(rptr_gray), 64'd0);
    checkOutput("rst_rd_level", 64'(rd_level), 64'd0);

    $display("[TB] single word");
    resetWriteSide();
    writeWord(41'h1_2345_6789A);
    applyStimulus(1'b1, 1'b0);
    checkOutput("single_empty_e1", 64'(empty), 64'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("single_empty_e2", 64'(empty), 64'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("single_empty_e3", 64'(empty), 64'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("single_rd_valid", 64'(rd_valid), 64'd1);
    checkOutput("single_rd_data", 64'(rd_data), 64'h1_2345_6789A);
    checkOutput("single_empty_after", 64'(empty), 64'd1);
    checkOutput("single_rptr_gray", 64'(rptr_gray), 64'b00001);

    $display("[TB] underflow");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("uf_underflow", 64'(underflow), 64'd1);
      checkOutput("uf_rptr_gray", 64'(rptr_gray), 64'b00001);
      checkOutput("uf_rd_valid", 64'(rd_valid), 64'd0);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("uf_cleared", 64'(underflow), 64'd0);

    $display("[TB] full depth");
    resetWriteSide();
    repeat (2) applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 16; k++) writeWord(randWord());
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("full_rd_level", 64'(rd_level), 64'd16);
    checkOutput("full_empty", 64'(empty), 64'd0);
    for (int k = 0; k < 16; k++) begin
      checkOutput("full_mem_raddr", 64'(mem_raddr), 64'(k));
      applyStimulus(1'b1, 1'b1);
    end
    checkOutput("full_empty_after", 64'(empty), 64'd1);
    checkOutput("full_rptr_gray", 64'(rptr_gray), 64'b11000);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] random stream across the pointer wrap");
    start_pops = m_rcnt;
    raddr_wraps = 0;
    wrap_gray_seen = 0;
    cycles = 0;
    while (cycles < 1000 && (m_rcnt - start_pops) < 40) begin
      if ($urandom_range(0, 1) == 1 && (wcnt - m_rcnt) < 16) writeWord(randWord());
      applyStimulus(1'b1, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      cycles++;
    end
    checkOutput("stream_pops_done", 64'((m_rcnt - start_pops) >= 40), 64'd1);
    checkOutput("stream_raddr_wraps", 64'(raddr_wraps >= 2), 64'd1);
    checkOutput("stream_gray_wrap", 64'(wrap_gray_seen >= 1), 64'd1);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] reset in the middle of a burst");
    resetWriteSide();
    repeat (2) applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) writeWord(randWord());
    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b1);
    checkOutput("mid_rptr_gray_5", 64'(rptr_gray), 64'b00111);
    resetWriteSide();
    applyStimulus(1'b0, 1'b1);
    checkOutput("mid_empty", 64'(empty), 64'd1);
    checkOutput("mid_rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("mid_rptr_gray", 64'(rptr_gray), 64'd0);
    checkOutput("mid_rd_level", 64'(rd_level), 64'd0);
    checkOutput("mid_mem_raddr", 64'(mem_raddr), 64'd0);
    repeat (3) applyStimulus(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
